// File: rtl/systolic_row_os.sv
// systolic_row_os: PE_NUM-cell signed MAC row, weight-stationary or output-stationary with serial drain.
// Define SYSTOLIC_ROW_SAT_EN to saturate sums instead of two's-complement wrap.
module systolic_row_os #(
  parameter int PE_NUM            = 16,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int WEIGHT_DATA_WIDTH = 8,
  parameter int OUTPUT_DATA_WIDTH = 20
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                mode,
  input  logic                                w_load,
  input  logic [WEIGHT_DATA_WIDTH-1:0]        w_in,
  input  logic                                w_in_valid,
  input  logic [INPUT_DATA_WIDTH-1:0]         in_a,
  input  logic                                in_a_valid,
  input  logic [OUTPUT_DATA_WIDTH*PE_NUM-1:0] in_b_bus,
  input  logic                                clear,
  input  logic                                drain_start,
  output logic [INPUT_DATA_WIDTH-1:0]         out_a,
  output logic                                out_a_valid,
  output logic [OUTPUT_DATA_WIDTH*PE_NUM-1:0] out_b_bus,
  output logic [PE_NUM-1:0]                   out_b_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0]        drain_data,
  output logic                                drain_valid,
  output logic                                busy
);
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int CW = $clog2(PE_NUM);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic signed [WEIGHT_DATA_WIDTH-1:0] r_w [PE_NUM];
  logic signed [INPUT_DATA_WIDTH-1:0] r_a [PE_NUM];
  logic signed [OW-1:0] r_b [PE_NUM];
  logic signed [OW-1:0] r_acc [PE_NUM];
  logic r_am [PE_NUM-1];
  logic [PE_NUM-1:0] r_av, r_bv;
  logic signed [INPUT_DATA_WIDTH-1:0] w_a_in [PE_NUM];
  logic signed [WEIGHT_DATA_WIDTH-1:0] w_w_prev [PE_NUM];
  logic signed [OW-1:0] w_acc_prev [PE_NUM];
  logic signed [OW-1:0] w_fmt [PE_NUM];
  logic [PE_NUM-1:0] w_v_in, w_m_in;
  logic w_idle, w_clr, w_drain_go, w_load_last, w_drain_last;
  assign w_idle       = r_state == IDLE;
  assign w_clr        = w_idle & clear;
  assign w_drain_go   = w_idle & ~w_load & drain_start & mode & ~in_a_valid & ~|r_av;
  assign w_load_last  = (r_state == LOAD) & w_in_valid & (r_cnt == CW'(PE_NUM - 1));
  assign w_drain_last = (r_state == DRAIN) & (r_cnt == CW'(PE_NUM - 1));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_idle) w_next = w_load ? LOAD : (w_drain_go ? DRAIN : IDLE);
    else if (w_load_last || w_drain_last) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_cnt <= '0;
    else if (w_idle) r_cnt <= '0;
    else if (r_state == DRAIN || w_in_valid) r_cnt <= r_cnt + 1'b1;
  for (genvar g = 0; g < PE_NUM; g++) begin : g_pe
    logic signed [OW-1:0] w_base;
    logic signed [INPUT_DATA_WIDTH+WEIGHT_DATA_WIDTH-1:0] w_p;
    if (g == 0) begin : g_head
      assign w_a_in[g]     = in_a;
      assign w_v_in[g]     = in_a_valid & w_idle;
      assign w_m_in[g]     = mode;
      assign w_w_prev[g]   = w_in;
      assign w_acc_prev[g] = '0;
    end else begin : g_link
      assign w_a_in[g]     = r_a[g-1];
      assign w_v_in[g]     = r_av[g-1];
      assign w_m_in[g]     = r_am[g-1];
      assign w_w_prev[g]   = r_w[g-1];
      assign w_acc_prev[g] = r_acc[g-1];
    end
    if (g < PE_NUM - 1) begin : g_mode
      // mode travels with each activation so in-flight data keeps the mode it was accepted under
      always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_am[g] <= 1'b0;
        else if (w_v_in[g]) r_am[g] <= w_m_in[g];
    end
    assign w_p    = w_a_in[g] * r_w[g];
    assign w_base = w_m_in[g] ? (w_clr ? '0 : r_acc[g]) : in_b_bus[g*OW +: OW];
`ifdef SYSTOLIC_ROW_SAT_EN
    logic signed [OW:0] w_sum;
    assign w_sum    = (OW+1)'(w_base) + (OW+1)'(w_p);
    assign w_fmt[g] = (w_sum[OW] != w_sum[OW-1]) ? {w_sum[OW], {(OW-1){~w_sum[OW]}}} : w_sum[OW-1:0];
`else
    assign w_fmt[g] = w_base + OW'(w_p);
`endif
    assign out_b_bus[g*OW +: OW] = r_b[g];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_av <= '0;
      r_bv <= '0;
      for (int i = 0; i < PE_NUM; i++) begin
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_acc[i] <= '0;
        r_w[i]   <= '0;
      end
    end else begin
      r_av <= w_v_in;
      r_bv <= w_v_in & ~w_m_in;
      for (int i = 0; i < PE_NUM; i++) begin
        if (w_v_in[i]) r_a[i] <= w_a_in[i];
        if (w_v_in[i] & ~w_m_in[i]) r_b[i] <= w_fmt[i];
        if (r_state == LOAD && w_in_valid) r_w[i] <= w_w_prev[i];
        if (r_state == DRAIN) r_acc[i] <= w_acc_prev[i];
        else if (w_v_in[i] & w_m_in[i]) r_acc[i] <= w_fmt[i];
        else if (w_clr) r_acc[i] <= '0;
      end
    end
  end
  assign out_a       = r_a[PE_NUM-1];
  assign out_a_valid = r_av[PE_NUM-1];
  assign out_b_valid = r_bv;
  assign drain_data  = r_acc[PE_NUM-1];
  assign drain_valid = r_state == DRAIN;
  assign busy        = r_state != IDLE;
endmodule
